// File: rtl/dot_pkg.sv
// Shared types for the dot update queue: screen geometry, drain FSM states, FIFO entry layout.
package dot_pkg;
  localparam int DOT_X_W  = 10;
  localparam int DOT_Y_W  = 9;
  localparam int DOT_ID_W = 32;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {IDLE, WR_X, WR_Y, DONE} dot_state_e;

  typedef struct packed {
    logic [DOT_ID_W-1:0] id;
    logic [DOT_X_W-1:0]  x;
    logic [DOT_Y_W-1:0]  y;
  } dot_entry_t;

  // Saturate coordinates to the visible area.
  function automatic dot_entry_t clamp_entry(input dot_entry_t e);
    dot_entry_t r;
    r   = e;
    r.x = (e.x > DOT_X_W'(SCREEN_W-1)) ? DOT_X_W'(SCREEN_W-1) : e.x;
    r.y = (e.y > DOT_Y_W'(SCREEN_H-1)) ? DOT_Y_W'(SCREEN_H-1) : e.y;
    return r;
  endfunction
endpackage

// File: rtl/dot_fifo.sv
// Synchronous first-word-fall-through FIFO of dot entries with registered full/empty.
module dot_fifo
  import dot_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  dot_entry_t               wr_data,
  output dot_entry_t               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  dot_entry_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count_nxt;
  logic                do_push, do_pop;

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/dot_update_queue.sv
// Buffers CPU dot moves and replays them as held x/y field writes once per frame.
// Define DOT_RANGE_CLAMP_EN to saturate stored coordinates to 639/479.
module dot_update_queue
  import dot_pkg::*;
#(
  parameter int NUM_DOTS = 70,
  parameter int DEPTH    = 16,
  parameter int HOLD     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_wren,
  input  logic [31:0]         cpu_id,
  input  logic [DOT_X_W-1:0]  cpu_x,
  input  logic [DOT_Y_W-1:0]  cpu_y,
  input  logic                frame_sync,
  output logic                dotWren,
  output logic                is_Yloc,
  output logic [31:0]         dotID,
  output logic [31:0]         dotLoc,
  output logic                full,
  output logic                overflow,
  output logic                frame_done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  dot_state_e    state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] drain_n, drained, count;
  logic          hold_last, pop, accept, id_ok, empty;
  dot_entry_t    wr_entry, raw_entry, head;

  assign id_ok     = cpu_id < 32'(NUM_DOTS);
  assign hold_last = hold_cnt == HW'(HOLD-1);
  assign pop       = (state == WR_Y) && hold_last;
  // A full FIFO still takes a push in the cycle the head leaves.
  assign accept    = cpu_wren && id_ok && (!full || pop);
  assign raw_entry = '{id: cpu_id, x: cpu_x, y: cpu_y};

`ifdef DOT_RANGE_CLAMP_EN
  assign wr_entry = clamp_entry(raw_entry);
`else
  assign wr_entry = raw_entry;
`endif

  dot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      drain_n  <= '0;
      drained  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= ((state == WR_X || state == WR_Y) && !hold_last) ? hold_cnt + HW'(1) : '0;
      // Drain length is frozen at the frame boundary; later pushes wait a frame.
      if (state == IDLE && frame_sync && !empty) begin
        drain_n <= count;
        drained <= '0;
      end else if (pop) begin
        drained <= drained + CW'(1);
      end
      if (cpu_wren && !accept) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    dotWren    = 1'b0;
    is_Yloc    = 1'b0;
    dotID      = '0;
    dotLoc     = '0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (frame_sync && !empty) state_nxt = WR_X;
      WR_X: begin
        dotWren = 1'b1;
        dotID   = head.id;
        dotLoc  = 32'(head.x);
        if (hold_last) state_nxt = WR_Y;
      end
      WR_Y: begin
        dotWren = 1'b1;
        is_Yloc = 1'b1;
        dotID   = head.id;
        dotLoc  = 32'(head.y);
        if (hold_last) state_nxt = (drained + CW'(1) < drain_n) ? WR_X : DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
